apb_slave: RTL
==============

// Module: apb_slave
// PURPOSE
//  APB completer (slave) with a word-addressed register file. Answers the APB
//  master's SETUP/ACCESS phases and inserts a programmable number of wait states.
//  Writes commit PWDATA; reads return PRDATA. Sits on the APB bus opposite the
//  master as the memory-mapped storage target.
// PARAMETERS
//  DEPTH       128  number of 32-bit words in the register file (power of 2)
//  WAIT_CYCLES 0    wait states inserted in every ACCESS phase (0..15)
// PORTS
//  PCLK     in   1   clock; all logic on posedge PCLK
//  PRESET   in   1   reset, synchronous, active-high
//  PSEL     in   1   slave select from master
//  PENABLE  in   1   ACCESS-phase strobe from master
//  PWRITE   in   1   1 = write, 0 = read
//  PADDR    in   32  byte address; word index = PADDR[2 +: log2(DEPTH)]
//  PWDATA   in   32  write data
//  PRDATA   out  32  read data, registered
//  PREADY   out  1   transfer-complete strobe
//  PSLVERR  out  1   error response (present only with APB_SLAVE_PSLVERR_EN)
// BEHAVIOUR
//  - Reset (PRESET=1 at posedge): state<=IDLE, wait_cnt<=0, PRDATA<=0,
//    all DEPTH words <=0. PREADY=0, PSLVERR=0. Reset wins over any activity;
//    a transfer in flight is dropped without committing.
//  - States: IDLE, ACCESS. 4-bit wait_cnt.
//  - IDLE: PSEL=1 & PENABLE=0 (SETUP) -> latch addr index, PWRITE, PWDATA,
//    error flag; wait_cnt<=WAIT_CYCLES; for reads PRDATA<=mem[idx]; -> ACCESS.
//    PSEL=1 & PENABLE=1 in IDLE (no prior setup) is a protocol error: ignored,
//    stay IDLE, PREADY=0.
//  - ACCESS: PREADY = (state==ACCESS && wait_cnt==0), combinational from regs.
//    wait_cnt!=0 -> decrement; stay ACCESS.
//    PSEL=1 & PENABLE=1 & PREADY=1 -> completion posedge: writes do
//    mem[idx]<=latched PWDATA; -> IDLE.
//    PSEL=0 or PENABLE=0 while in ACCESS -> abort: no write, -> IDLE.
//  - Latency: WAIT_CYCLES=0 -> PREADY high in first ACCESS cycle (2-cycle
//    transfer). N wait states -> PREADY in ACCESS cycle N+1.
//  - Back-to-back: after completion the slave is IDLE; the master's next SETUP
//    cycle is accepted immediately, no dead cycle beyond APB's own SETUP.
//  - PRDATA holds its last value outside read ACCESS; writes do not change it.
//  - Address bits [1:0] and bits above the index are ignored (aliasing) unless
//    the error feature is compiled in.
//  - Read of a word written in the immediately preceding transfer returns the
//    new value (write commits before next SETUP samples memory).
// CONFIGURATION
//  APB_SLAVE_PSLVERR_EN defined: PSLVERR port exists. Error flag latched in
//  SETUP = (PADDR[1:0]!=0) | (PADDR[31:2+log2(DEPTH)]!=0). PSLVERR = PREADY &
//  err_flag. Erroring write: memory unchanged. Erroring read: PRDATA<=0.
//  Not defined: no PSLVERR port, no error check, aliasing as above.
// TESTING
//  1 Reset: PRESET=1 two cycles mid-transfer -> PREADY=0, PRDATA=0, read of
//    0x10 afterwards returns 0.
//  2 WAIT_CYCLES=0: write 0xDEADBEEF @0x04 then read @0x04 -> PREADY in each
//    ACCESS cycle 1, PRDATA=0xDEADBEEF.
//  3 WAIT_CYCLES=3: read @0x08 -> PREADY low 3 ACCESS cycles, high on 4th.
//  4 Abort: PSEL drops during wait of write 0x1234 @0x0C -> read @0x0C = 0.
//  5 Aliasing (no macro): write 0xA5A5A5A5 @0x200 -> read @0x000 = 0xA5A5A5A5.
//  6 APB_SLAVE_PSLVERR_EN: write @0x201 -> PSLVERR=1 with PREADY, @0x200
//    unchanged; read @0x400 -> PSLVERR=1, PRDATA=0.

Source files
------------

// File: rtl/apb_slave.sv
// -----------------------------------------------------------------------------
// apb_slave
//   APB completer backed by a word-addressed register file of DEPTH 32-bit
//   words. Every ACCESS phase is stretched by WAIT_CYCLES wait states. Read
//   data is fetched in the SETUP cycle and held in PRDATA. Write data is
//   latched in SETUP and committed on the completing ACCESS edge.
//
//   Optional feature (compile-time macro APB_SLAVE_PSLVERR_EN):
//     adds the PSLVERR port. Unaligned addresses and addresses beyond the
//     register file are flagged as errors. A flagged write leaves memory
//     untouched and a flagged read returns zero. Without the macro, address
//     bits outside the word index are ignored, so the file aliases across
//     the address space.
//
// Ports
//   PCLK     in   1   clock, rising edge
//   PRESET   in   1   synchronous active-high reset
//   PSEL     in   1   slave select
//   PENABLE  in   1   ACCESS-phase strobe
//   PWRITE   in   1   1 = write, 0 = read
//   PADDR    in   32  byte address, word index = PADDR[2 +: log2(DEPTH)]
//   PWDATA   in   32  write data
//   PRDATA   out  32  registered read data
//   PREADY   out  1   transfer complete
//   PSLVERR  out  1   error response (APB_SLAVE_PSLVERR_EN only)
// -----------------------------------------------------------------------------
module apb_slave #(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY
`ifdef APB_SLAVE_PSLVERR_EN
    ,
    output logic        PSLVERR
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               write_q, write_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               err_q, err_d;
    logic [31:0]        prdata_q, prdata_d;
    logic [31:0]        mem_q [DEPTH];
    logic               mem_we;

    logic [IDX_W-1:0]   setup_idx;
    logic               addr_err;
    logic               ready;

    assign setup_idx = PADDR[2 +: IDX_W];

`ifdef APB_SLAVE_PSLVERR_EN
    assign addr_err = (PADDR[1:0] != 2'b00) || (PADDR[31:2+IDX_W] != '0);
`else
    // Bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{PADDR[31:2+IDX_W], PADDR[1:0]};
    assign addr_err         = 1'b0;
`endif

    // Ready depends only on registered state, never on the bus inputs.
    assign ready  = (state_q == ACCESS) && (wait_cnt_q == 4'd0);
    assign PREADY = ready;
    assign PRDATA = prdata_q;

`ifdef APB_SLAVE_PSLVERR_EN
    assign PSLVERR = ready && err_q;
`endif

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        prdata_d   = prdata_q;
        mem_we     = 1'b0;

        if (state_q == IDLE) begin
            // SETUP only; PSEL+PENABLE without a prior SETUP is ignored.
            if (PSEL && !PENABLE) begin
                state_d    = ACCESS;
                idx_d      = setup_idx;
                write_d    = PWRITE;
                wdata_d    = PWDATA;
                err_d      = addr_err;
                wait_cnt_d = 4'(WAIT_CYCLES);
                // Memory is sampled here, so a write committed on the
                // previous edge is already visible to a back-to-back read.
                if (!PWRITE) begin
                    prdata_d = addr_err ? 32'd0 : mem_q[setup_idx];
                end
            end
        end else begin
            if (!PSEL || !PENABLE) begin
                // Master abandoned the transfer: drop it without committing.
                state_d = IDLE;
            end else if (ready) begin
                state_d = IDLE;
                mem_we  = write_q && !err_q;
            end else begin
                wait_cnt_d = wait_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
            idx_q      <= '0;
            write_q    <= 1'b0;
            wdata_q    <= 32'd0;
            err_q      <= 1'b0;
            prdata_q   <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            idx_q      <= idx_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            prdata_q   <= prdata_d;
            if (mem_we) begin
                mem_q[idx_q] <= wdata_q;
            end
        end
    end

endmodule
